// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register:
// ALUOp encodings, the control-word layout and the bubble control word.
package id_ex_reg_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int OPC_W  = 11;

  localparam logic [1:0] ALUOP_DTYPE  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // Control word: everything that must be squashed to form a bubble.
  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             branch;
    logic             uncond_branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '{
    valid:         1'b0,
    opcode:        '0,
    alu_op:        ALUOP_DTYPE,
    alu_src:       1'b0,
    mem_read:      1'b0,
    mem_write:     1'b0,
    mem_to_reg:    1'b0,
    reg_write:     1'b0,
    branch:        1'b0,
    uncond_branch: 1'b0
  };

  // Datapath word: held (not cleared) when a bubble is inserted.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] sign_ext_imm;
    logic [REG_W-1:0]  write_reg;
  } dp_t;

  localparam int DP_W  = $bits(dp_t);
  localparam int FWD_W = 2 * REG_W;

endpackage

// File: rtl/id_ex_reg_pipe_field_reg.sv
// Generic pipeline field register: reset > clear-to-value > enable-load > hold.
module pipe_field_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] clr_val,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_q;

  // Field state: synchronous reset, then clear, then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset)
      r_q <= '0;
    else if (clr)
      r_q <= clr_val;
    else if (en)
      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold and flush/invalid bubble insertion.
// Optional macro ID_EX_FWD_EN adds registered rn/rm source-register fields
// for the forwarding unit.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_sign_ext_imm,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_W-1:0]  id_write_reg,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              id_uncond_branch,
  output logic              id_ready,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_sign_ext_imm,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [1:0]        ex_alu_op,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              ex_uncond_branch,
  output logic              ex_valid
`ifdef ID_EX_FWD_EN
  ,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  output logic [REG_W-1:0]  ex_rn,
  output logic [REG_W-1:0]  ex_rm
`endif
);

  ctrl_t w_ctrl_d;
  ctrl_t w_ctrl_q;
  dp_t   w_dp_d;
  dp_t   w_dp_q;
  logic  w_ctrl_en;
  logic  w_ctrl_clr;
  logic  w_dp_en;

  // Control word bubbles on flush (even under stall) or on a load of an
  // invalid slot; datapath fields only advance on a load of a real instruction.
  assign w_ctrl_en  = !stall;
  assign w_ctrl_clr = flush | (!stall & !id_valid);
  assign w_dp_en    = !stall & !flush & id_valid;
  assign id_ready   = !stall;

  assign w_ctrl_d = '{
    valid:         id_valid,
    opcode:        id_opcode,
    alu_op:        id_alu_op,
    alu_src:       id_alu_src,
    mem_read:      id_mem_read,
    mem_write:     id_mem_write,
    mem_to_reg:    id_mem_to_reg,
    reg_write:     id_reg_write,
    branch:        id_branch,
    uncond_branch: id_uncond_branch
  };

  assign w_dp_d = '{
    pc:           id_pc,
    read_data1:   id_read_data1,
    read_data2:   id_read_data2,
    sign_ext_imm: id_sign_ext_imm,
    write_reg:    id_write_reg
  };

  pipe_field_reg #(.DATA_W(CTRL_W)) u_ctrl_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (w_ctrl_en),
    .clr     (w_ctrl_clr),
    .clr_val (CTRL_BUBBLE),
    .d       (w_ctrl_d),
    .q       (w_ctrl_q)
  );

  pipe_field_reg #(.DATA_W(DP_W)) u_dp_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (w_dp_en),
    .clr     (1'b0),
    .clr_val ({DP_W{1'b0}}),
    .d       (w_dp_d),
    .q       (w_dp_q)
  );

`ifdef ID_EX_FWD_EN
  logic [FWD_W-1:0] w_fwd_q;

  pipe_field_reg #(.DATA_W(FWD_W)) u_fwd_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (w_dp_en),
    .clr     (1'b0),
    .clr_val ({FWD_W{1'b0}}),
    .d       ({id_rn, id_rm}),
    .q       (w_fwd_q)
  );

  assign ex_rn = w_fwd_q[FWD_W-1:REG_W];
  assign ex_rm = w_fwd_q[REG_W-1:0];
`endif

  assign ex_valid         = w_ctrl_q.valid;
  assign ex_opcode        = w_ctrl_q.opcode;
  assign ex_alu_op        = w_ctrl_q.alu_op;
  assign ex_alu_src       = w_ctrl_q.alu_src;
  assign ex_mem_read      = w_ctrl_q.mem_read;
  assign ex_mem_write     = w_ctrl_q.mem_write;
  assign ex_mem_to_reg    = w_ctrl_q.mem_to_reg;
  assign ex_reg_write     = w_ctrl_q.reg_write;
  assign ex_branch        = w_ctrl_q.branch;
  assign ex_uncond_branch = w_ctrl_q.uncond_branch;

  assign ex_pc            = w_dp_q.pc;
  assign ex_read_data1    = w_dp_q.read_data1;
  assign ex_read_data2    = w_dp_q.read_data2;
  assign ex_sign_ext_imm  = w_dp_q.sign_ext_imm;
  assign ex_write_reg     = w_dp_q.write_reg;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, hold current contents (hazard unit).
REQ-004 SHALL have port flush, input, 1, replace next contents with a bubble (branch taken).
REQ-005 SHALL have port id_valid, input, 1, decode stage holds a real instruction.
REQ-006 SHALL have ports id_pc, id_read_data1, id_read_data2, id_sign_ext_imm, input, 64 each, decode datapath values.
REQ-007 SHALL have ports id_opcode (11), id_alu_op (2), id_write_reg (5), input, instruction opcode, ALU-op class, destination register.
REQ-008 SHALL have ports id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch, id_uncond_branch, input, 1 each, decode control bits.
REQ-009 SHALL have matching ex_* outputs (same names with ex_ prefix, same widths) plus ex_valid, output, 1.
REQ-010 SHALL have port id_ready, output, 1, decode may advance; equals !stall combinationally.

Function
REQ-011 Per-edge priority SHALL be reset > flush > stall > load.
REQ-012 Load (no reset/flush/stall) SHALL register every id_* field into ex_* with exactly one cycle latency; ex_valid <= id_valid.
REQ-013 Load with id_valid=0 SHALL register a bubble (REQ-015) rather than the decode control bits.
REQ-014 Stall (no flush) SHALL keep every ex_* output and ex_valid unchanged for as many consecutive cycles as asserted.
REQ-015 Bubble SHALL set ex_valid=0, ex_mem_read=ex_mem_write=ex_reg_write=ex_branch=ex_uncond_branch=ex_mem_to_reg=ex_alu_src=0, ex_alu_op=ALUOp_DTYPE (2'b00), ex_opcode=0; datapath fields (pc, read data, imm, write_reg) SHALL hold their previous value.
REQ-016 Flush SHALL produce a bubble on the next edge even when stall is also asserted.
REQ-017 Outputs SHALL be driven only from registers; no combinational id_* -> ex_* path.
REQ-018 First load after stall deassertion SHALL capture id_* present in that cycle (decode held stable by id_ready).

Reset
REQ-019 Reset SHALL clear every ex_* output, including 64-bit fields, to 0 and ex_valid to 0 on the next rising edge.
REQ-020 Reset asserted mid-stall or with flush SHALL still clear all state; stall/flush ignored that cycle.
REQ-021 First edge after reset deassertion SHALL behave per REQ-011 with no extra idle cycle.

Configuration
REQ-022 Macro ID_EX_FWD_EN defined SHALL add inputs id_rn, id_rm (5 each) and outputs ex_rn, ex_rm (5 each), registered with the datapath-field rules (load, hold on stall/bubble, 0 on reset) for the forwarding unit.
REQ-023 Macro undefined SHALL omit those ports and registers entirely; all other behaviour identical.

Structure
REQ-024 ALUOp_* encodings (DTYPE, RTYPE, BRANCH) SHALL come from the shared definitions.vh header; no local literal for the bubble alu_op.
REQ-025 Bubble control word width and field layout SHALL be defined once as constants in definitions.vh.
REQ-026 One sub-module pipe_field_reg (parameterised width, inputs en, clr, clr_val) SHALL be instantiated per field group (control, datapath, forwarding).

Verification
REQ-027 Reset held 2 cycles with all id_* = all-ones -> all ex_* = 0, ex_valid=0 after the first edge.
REQ-028 Load id_pc=64'h40, id_alu_op=2'b10, id_opcode=11'h458, id_reg_write=1, id_valid=1 -> next cycle ex_pc=64'h40, ex_alu_op=2'b10, ex_opcode=11'h458, ex_reg_write=1, ex_valid=1.
REQ-029 Stall 3 cycles while id_* changes each cycle -> ex_* unchanged for 3 cycles; id_ready=0 during stall; 4th cycle captures new id_*.
REQ-030 flush=1 and stall=1 together with ex holding id_mem_write=1 -> next cycle ex_valid=0, ex_mem_write=0, ex_alu_op=2'b00, ex_pc unchanged.
REQ-031 id_valid=0 with id_reg_write=1, id_branch=1 -> next cycle ex_reg_write=0, ex_branch=0, ex_valid=0.
REQ-032 Build with ID_EX_FWD_EN, id_rn=5'd3, id_rm=5'd31 loaded then reset -> ex_rn=3, ex_rm=31 after load, both 0 after reset.
